// File: rtl/tcm_mem_pkg.sv
// Shared types and constants for the latency-configurable TCM memory model.
// Holds the data-response record carried through the outstanding-request queue.
package tcm_mem_pkg;

   localparam int TAG_W = 11;

   typedef struct packed {
      logic [31:0]      data;
      logic             error;
      logic [TAG_W-1:0] tag;
   } tcm_d_resp_t;

   // Fibonacci LFSR, taps 16,14,13,11 mapped onto bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic lfsr_fb(input logic [15:0] s);
      return ^(s & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/tcm_mem_lat_if.sv
// Fetch and data bus bundle between a core (master) and the TCM model (slave).
interface tcm_mem_lat_if;
   import tcm_mem_pkg::*;

   logic             mem_i_rd_i;
   logic             mem_i_flush_i;
   logic             mem_i_invalidate_i;
   logic [31:0]      mem_i_pc_i;
   logic             mem_i_accept_o;
   logic             mem_i_valid_o;
   logic             mem_i_error_o;
   logic [31:0]      mem_i_inst_o;

   logic [31:0]      mem_d_addr_i;
   logic [31:0]      mem_d_data_wr_i;
   logic             mem_d_rd_i;
   logic [3:0]       mem_d_wr_i;
   logic             mem_d_cacheable_i;
   logic [TAG_W-1:0] mem_d_req_tag_i;
   logic             mem_d_invalidate_i;
   logic             mem_d_writeback_i;
   logic             mem_d_flush_i;
   logic [31:0]      mem_d_data_rd_o;
   logic             mem_d_accept_o;
   logic             mem_d_ack_o;
   logic             mem_d_error_o;
   logic [TAG_W-1:0] mem_d_resp_tag_o;

   modport master (
      output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
      input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
      output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
      output mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
      input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
   );

   modport slave (
      input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
      output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
      input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
      input  mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
      output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
   );

endinterface

// File: rtl/tcm_resp_fifo.sv
// In-order data-response queue; each entry counts down its own latency and
// the head may only leave once its countdown has reached zero.
module tcm_resp_fifo
   import tcm_mem_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_push,
   input  tcm_d_resp_t            i_entry,
   input  logic                   i_pop,
   output tcm_d_resp_t            o_head,
   output logic                   o_head_rdy,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

   tcm_d_resp_t      r_data [DEPTH];
   logic [CNT_W-1:0] r_cnt  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
         end
         // a fresh push overrides the decrement applied to its slot
         if (i_push) begin
            r_cnt[r_wr_ptr] <= CNT_INIT;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (i_push) r_data[r_wr_ptr] <= i_entry;
   end

   assign o_head     = r_data[r_rd_ptr];
   assign o_head_rdy = (r_count != '0) && (r_cnt[r_rd_ptr] == '0);
   assign o_full     = (r_count == FULL_CNT);
   assign o_count    = r_count;

endmodule

// File: rtl/tcm_mem_lat.sv
// Dual-port TCM model with per-port latency, in-order tagged data responses,
// range errors, periodic back-pressure and a byte backdoor. Optional random
// back-pressure is enabled with `define TCM_MEM_RAND_STALL_EN.
module tcm_mem_lat
   import tcm_mem_pkg::*;
#(
   parameter int          MEM_AW       = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h80000000,
   parameter int          I_LATENCY    = 1,
   parameter int          D_LATENCY    = 1,
   parameter int          D_DEPTH      = 4,
   parameter int          STALL_PERIOD = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   tcm_mem_lat_if.slave      bus,
   input  logic              bd_wr_i,
   input  logic [MEM_AW-1:0] bd_addr_i,
   input  logic [7:0]        bd_data_i
);

   localparam int WORDS = 2 ** (MEM_AW - 2);
   localparam int CW    = $clog2(D_DEPTH) + 1;

   function automatic logic in_range(input logic [31:0] a);
      return (a >> MEM_AW) == (BASE_ADDR >> MEM_AW);
   endfunction

   logic [31:0] r_mem [WORDS];

   logic w_stall;
   logic w_i_rand_blk;
   logic w_d_rand_blk;

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         logic [31:0] r_stall_cnt;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)                                    r_stall_cnt <= '0;
            else if (r_stall_cnt == 32'(STALL_PERIOD - 1)) r_stall_cnt <= '0;
            else                                            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         assign w_stall = (r_stall_cnt == 32'(STALL_PERIOD - 1));
      end else begin : g_no_stall
         assign w_stall = 1'b0;
      end
   endgenerate

`ifdef TCM_MEM_RAND_STALL_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_lfsr <= LFSR_SEED;
      else         r_lfsr <= {r_lfsr[14:0], lfsr_fb(r_lfsr)};
   end
   assign w_i_rand_blk = (r_lfsr[1:0] == 2'b00);
   assign w_d_rand_blk = (r_lfsr[3:2] == 2'b00);
`else
   assign w_i_rand_blk = 1'b0;
   assign w_d_rand_blk = 1'b0;
`endif

   // Fetch port: read at accept, then delay through the valid/data pipe
   logic                 w_i_accept;
   logic                 w_i_fire;
   logic                 w_i_in_rng;
   logic [MEM_AW-3:0]    w_i_idx;
   logic [I_LATENCY-1:0] r_i_vld;
   logic [I_LATENCY-1:0] r_i_err;
   logic [31:0]          r_i_inst [I_LATENCY];

   // gating with rst_ni keeps the accepts low for the whole reset window
   assign w_i_accept = rst_ni & ~w_stall & ~w_i_rand_blk;
   assign w_i_fire   = w_i_accept & bus.mem_i_rd_i;
   assign w_i_in_rng = in_range(bus.mem_i_pc_i);
   assign w_i_idx    = bus.mem_i_pc_i[MEM_AW-1:2];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_i_vld <= '0;
         r_i_err <= '0;
         for (int s = 0; s < I_LATENCY; s++) r_i_inst[s] <= '0;
      end else begin
         r_i_vld[0]  <= w_i_fire;
         r_i_err[0]  <= w_i_fire & ~w_i_in_rng;
         r_i_inst[0] <= (w_i_fire && w_i_in_rng) ? r_mem[w_i_idx] : 32'h0;
         for (int s = 1; s < I_LATENCY; s++) begin
            r_i_vld[s]  <= r_i_vld[s-1];
            r_i_err[s]  <= r_i_err[s-1];
            r_i_inst[s] <= r_i_inst[s-1];
         end
      end
   end

   assign bus.mem_i_accept_o = w_i_accept;
   assign bus.mem_i_valid_o  = r_i_vld[I_LATENCY-1];
   assign bus.mem_i_error_o  = r_i_err[I_LATENCY-1];
   assign bus.mem_i_inst_o   = r_i_inst[I_LATENCY-1];

   // Data port
   logic              w_d_req;
   logic              w_d_accept;
   logic              w_d_fire;
   logic              w_d_in_rng;
   logic              w_d_wr_en;
   logic [MEM_AW-3:0] w_d_idx;
   tcm_d_resp_t       w_d_entry;
   tcm_d_resp_t       w_head;
   logic              w_head_rdy;
   logic              w_full;
   logic [CW-1:0]     w_count;

   assign w_d_req    = bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_invalidate_i
                     | bus.mem_d_writeback_i | bus.mem_d_flush_i;
   assign w_d_accept = rst_ni & ~w_stall & ~w_d_rand_blk & (w_count < CW'(D_DEPTH));
   assign w_d_fire   = w_d_accept & w_d_req;
   assign w_d_in_rng = in_range(bus.mem_d_addr_i);
   assign w_d_wr_en  = w_d_fire & w_d_in_rng & (|bus.mem_d_wr_i);
   assign w_d_idx    = bus.mem_d_addr_i[MEM_AW-1:2];

   always_comb begin
      w_d_entry       = '0;
      w_d_entry.data  = (bus.mem_d_rd_i && w_d_in_rng) ? r_mem[w_d_idx] : 32'h0;
      w_d_entry.error = ~w_d_in_rng;
      w_d_entry.tag   = bus.mem_d_req_tag_i;
   end

   // backdoor byte is written last so it wins over a same-byte data write
   always_ff @(posedge clk_i) begin
      if (w_d_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_d_wr_i[b]) r_mem[w_d_idx][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
         end
      end
      if (bd_wr_i) r_mem[bd_addr_i[MEM_AW-1:2]][{bd_addr_i[1:0], 3'b000} +: 8] <= bd_data_i;
   end

   tcm_resp_fifo #(
      .DEPTH   (D_DEPTH),
      .LATENCY (D_LATENCY)
   ) u_resp_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_push     (w_d_fire),
      .i_entry    (w_d_entry),
      .i_pop      (w_head_rdy),
      .o_head     (w_head),
      .o_head_rdy (w_head_rdy),
      .o_full     (w_full),
      .o_count    (w_count)
   );

   assign bus.mem_d_accept_o   = w_d_accept;
   assign bus.mem_d_ack_o      = w_head_rdy;
   assign bus.mem_d_data_rd_o  = w_head_rdy ? w_head.data : 32'h0;
   assign bus.mem_d_error_o    = w_head_rdy & w_head.error;
   assign bus.mem_d_resp_tag_o = w_head_rdy ? w_head.tag : '0;

   logic w_unused;
   assign w_unused = ^{bus.mem_d_cacheable_i, bus.mem_i_flush_i, bus.mem_i_invalidate_i,
                       bus.mem_i_pc_i[1:0], bus.mem_d_addr_i[1:0], w_full};

endmodule

// File: tb/tb_tcm_mem_lat.sv
// Directed bench for tcm_mem_lat: DUT A (I_LATENCY=3, D_LATENCY=8, D_DEPTH=4)
// and DUT B (STALL_PERIOD=4, single-cycle latencies) with response scoreboards.
module tb_tcm_mem_lat;
   import tcm_mem_pkg::*;

   logic clk = 1'b0;
   logic rst_na = 1'b0;
   logic rst_nb = 1'b0;
   logic       bd_wr_a = 1'b0, bd_wr_b = 1'b0;
   logic [15:0] bd_addr_a = '0, bd_addr_b = '0;
   logic [7:0]  bd_data_a = '0, bd_data_b = '0;

   int checks = 0;
   int failures = 0;
   tcm_d_resp_t q_a[$];
   tcm_d_resp_t q_b[$];

   tcm_mem_lat_if ifa();
   tcm_mem_lat_if ifb();

   always #5 clk = ~clk;

   tcm_mem_lat #(.I_LATENCY(3), .D_LATENCY(8), .D_DEPTH(4), .STALL_PERIOD(0)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_na), .bus(ifa),
      .bd_wr_i(bd_wr_a), .bd_addr_i(bd_addr_a), .bd_data_i(bd_data_a));

   tcm_mem_lat #(.I_LATENCY(1), .D_LATENCY(1), .D_DEPTH(4), .STALL_PERIOD(4)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_nb), .bus(ifb),
      .bd_wr_i(bd_wr_b), .bd_addr_i(bd_addr_b), .bd_data_i(bd_data_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic tcm_d_resp_t mk(input logic [31:0] d, input logic e, input int t);
      tcm_d_resp_t r;
      r.data = d; r.error = e; r.tag = TAG_W'(t);
      return r;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_a();
      ifa.mem_i_rd_i = 0; ifa.mem_i_flush_i = 0; ifa.mem_i_invalidate_i = 0;
      ifa.mem_d_rd_i = 0; ifa.mem_d_wr_i = '0; ifa.mem_d_cacheable_i = 0;
      ifa.mem_d_invalidate_i = 0; ifa.mem_d_writeback_i = 0; ifa.mem_d_flush_i = 0;
   endtask

   task automatic idle_b();
      ifb.mem_i_rd_i = 0; ifb.mem_i_flush_i = 0; ifb.mem_i_invalidate_i = 0;
      ifb.mem_d_rd_i = 0; ifb.mem_d_wr_i = '0; ifb.mem_d_cacheable_i = 0;
      ifb.mem_d_invalidate_i = 0; ifb.mem_d_writeback_i = 0; ifb.mem_d_flush_i = 0;
   endtask

   task automatic bd_word(input bit sel_b, input logic [15:0] off, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         if (sel_b) begin bd_wr_b = 1; bd_addr_b = off + 16'(b); bd_data_b = w[8*b +: 8]; end
         else       begin bd_wr_a = 1; bd_addr_a = off + 16'(b); bd_data_a = w[8*b +: 8]; end
         step();
      end
      bd_wr_a = 0; bd_wr_b = 0;
   endtask

   task automatic drain_a();
      for (int k = 0; k < 40 && q_a.size() != 0; k++) step();
      chk("a_drain", 32'(q_a.size()), 32'd0);
   endtask

   // Response scoreboards
   always @(negedge clk) begin
      tcm_d_resp_t e;
      if (ifa.mem_d_ack_o) begin
         if (q_a.size() == 0) chk("a_unexpected_ack", 32'(ifa.mem_d_ack_o), 32'd0);
         else begin
            e = q_a.pop_front();
            chk("a_rdata", ifa.mem_d_data_rd_o, e.data);
            chk("a_err", 32'(ifa.mem_d_error_o), 32'(e.error));
            chk("a_tag", 32'(ifa.mem_d_resp_tag_o), 32'(e.tag));
         end
      end
   end

   always @(negedge clk) begin
      tcm_d_resp_t e;
      if (ifb.mem_d_ack_o) begin
         if (q_b.size() == 0) chk("b_unexpected_ack", 32'(ifb.mem_d_ack_o), 32'd0);
         else begin
            e = q_b.pop_front();
            chk("b_rdata", ifb.mem_d_data_rd_o, e.data);
            chk("b_err", 32'(ifb.mem_d_error_o), 32'(e.error));
            chk("b_tag", 32'(ifb.mem_d_resp_tag_o), 32'(e.tag));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int lows;
      idle_a(); idle_b();
      ifa.mem_i_pc_i = '0; ifa.mem_d_addr_i = '0; ifa.mem_d_data_wr_i = '0; ifa.mem_d_req_tag_i = '0;
      ifb.mem_i_pc_i = '0; ifb.mem_d_addr_i = '0; ifb.mem_d_data_wr_i = '0; ifb.mem_d_req_tag_i = '0;
      #1;
      // backdoor preload while both DUTs are held in reset
      bd_word(0, 16'h0000, 32'h00000013);
      bd_word(0, 16'h0100, 32'h11223344);
      bd_word(0, 16'h0200, 32'h55667788);
      bd_word(1, 16'h0000, 32'hA5A50001);
      @(negedge clk);
      chk("rst_i_accept", 32'(ifa.mem_i_accept_o), 32'd0);
      chk("rst_d_accept", 32'(ifa.mem_d_accept_o), 32'd0);
      chk("rst_i_valid", 32'(ifa.mem_i_valid_o), 32'd0);
      chk("rst_d_ack", 32'(ifa.mem_d_ack_o), 32'd0);
      chk("rst_b_d_accept", 32'(ifb.mem_d_accept_o), 32'd0);
      step(); rst_na = 1; rst_nb = 1;

      // fetch latency
      step(); ifa.mem_i_rd_i = 1; ifa.mem_i_pc_i = 32'h80000000;
      @(negedge clk); chk("f_accept", 32'(ifa.mem_i_accept_o), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step(); ifa.mem_i_rd_i = 0;
         @(negedge clk); chk("f_valid", 32'(ifa.mem_i_valid_o), 32'(k == 3));
         if (k == 3) begin
            chk("f_inst", ifa.mem_i_inst_o, 32'h00000013);
            chk("f_err", 32'(ifa.mem_i_error_o), 32'd0);
         end
      end

      // byte-enabled write then tagged read
      step(); ifa.mem_d_addr_i = 32'h80000100; ifa.mem_d_data_wr_i = 32'hDEADBEEF;
      ifa.mem_d_wr_i = 4'b0101; ifa.mem_d_req_tag_i = 11'd1;
      @(negedge clk); chk("w_accept", 32'(ifa.mem_d_accept_o), 32'd1); q_a.push_back(mk(32'h0, 0, 1));
      step(); ifa.mem_d_wr_i = '0; ifa.mem_d_rd_i = 1; ifa.mem_d_req_tag_i = 11'h7FF;
      @(negedge clk); chk("r_accept", 32'(ifa.mem_d_accept_o), 32'd1); q_a.push_back(mk(32'h11AD33EF, 0, 11'h7FF));
      step(); idle_a();
      drain_a();

      // out-of-range on both ports
      step(); ifa.mem_d_addr_i = 32'h00001000; ifa.mem_d_rd_i = 1; ifa.mem_d_req_tag_i = 11'd5;
      ifa.mem_i_pc_i = 32'h00001000; ifa.mem_i_rd_i = 1;
      @(negedge clk); chk("oor_d_accept", 32'(ifa.mem_d_accept_o), 32'd1); q_a.push_back(mk(32'h0, 1, 5));
      step(); idle_a();
      step(); step();
      @(negedge clk);
      chk("oor_f_valid", 32'(ifa.mem_i_valid_o), 32'd1);
      chk("oor_f_err", 32'(ifa.mem_i_error_o), 32'd1);
      chk("oor_f_inst", ifa.mem_i_inst_o, 32'h0);
      drain_a();

      // same-cycle fetch, data write and backdoor to one word
      step(); ifa.mem_d_addr_i = 32'h80000200; ifa.mem_d_data_wr_i = 32'hAAAAAAAA;
      ifa.mem_d_wr_i = 4'hF; ifa.mem_d_req_tag_i = 11'd2; ifa.mem_i_rd_i = 1; ifa.mem_i_pc_i = 32'h80000200;
      bd_wr_a = 1; bd_addr_a = 16'h0203; bd_data_a = 8'h5A;
      @(negedge clk); chk("col_accept", 32'(ifa.mem_d_accept_o), 32'd1); q_a.push_back(mk(32'h0, 0, 2));
      step(); idle_a(); bd_wr_a = 0;
      step(); step();
      @(negedge clk); chk("col_f_old", ifa.mem_i_inst_o, 32'h55667788);
      step(); ifa.mem_d_rd_i = 1; ifa.mem_d_req_tag_i = 11'd3;
      @(negedge clk); q_a.push_back(mk(32'h5AAAAAAA, 0, 3));
      step(); idle_a();
      drain_a();

      // outstanding queue fill with D_DEPTH=4, D_LATENCY=8
      sent = 0;
      ifa.mem_d_addr_i = 32'h80000000;
      for (int k = 0; k < 30; k++) begin
         step();
         ifa.mem_d_rd_i = (sent < 6); ifa.mem_d_req_tag_i = TAG_W'(sent);
         @(negedge clk);
         if (k <= 8) chk("q_accept", 32'(ifa.mem_d_accept_o), 32'(k < 4));
         if (k <= 8) chk("q_ack", 32'(ifa.mem_d_ack_o), 32'(k == 8));
         if (ifa.mem_d_rd_i && ifa.mem_d_accept_o) begin
            q_a.push_back(mk(32'h00000013, 0, sent));
            sent++;
         end
      end
      step(); idle_a();
      chk("q_sent", 32'(sent), 32'd6);
      drain_a();

      // reset with responses pending
      for (int k = 0; k < 3; k++) begin
         step(); ifa.mem_d_rd_i = 1; ifa.mem_d_addr_i = 32'h80000100; ifa.mem_d_req_tag_i = TAG_W'(10 + k);
         ifa.mem_i_rd_i = 1; ifa.mem_i_pc_i = 32'h80000000;
         @(negedge clk); chk("pr_accept", 32'(ifa.mem_d_accept_o), 32'd1);
      end
      step(); idle_a();
      #2 rst_na = 0;
      #1;
      chk("ar_i_accept", 32'(ifa.mem_i_accept_o), 32'd0);
      chk("ar_i_valid", 32'(ifa.mem_i_valid_o), 32'd0);
      chk("ar_i_err", 32'(ifa.mem_i_error_o), 32'd0);
      chk("ar_i_inst", ifa.mem_i_inst_o, 32'h0);
      chk("ar_d_accept", 32'(ifa.mem_d_accept_o), 32'd0);
      chk("ar_d_ack", 32'(ifa.mem_d_ack_o), 32'd0);
      chk("ar_d_err", 32'(ifa.mem_d_error_o), 32'd0);
      chk("ar_d_data", ifa.mem_d_data_rd_o, 32'h0);
      chk("ar_d_tag", 32'(ifa.mem_d_resp_tag_o), 32'd0);
      step(); step(); rst_na = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("post_rst_ack", 32'(ifa.mem_d_ack_o), 32'd0);
         chk("post_rst_ivld", 32'(ifa.mem_i_valid_o), 32'd0);
         step();
      end
      ifa.mem_d_rd_i = 1; ifa.mem_d_addr_i = 32'h80000100; ifa.mem_d_req_tag_i = 11'd3;
      @(negedge clk); chk("ret_accept", 32'(ifa.mem_d_accept_o), 32'd1); q_a.push_back(mk(32'h11AD33EF, 0, 3));
      step(); idle_a();
      drain_a();

      // periodic stall on DUT B, counter restarted by reset
      step(); rst_nb = 0;
      step();
      ifb.mem_i_rd_i = 1; ifb.mem_i_pc_i = 32'h80000000;
      ifb.mem_d_rd_i = 1; ifb.mem_d_addr_i = 32'h80000000; ifb.mem_d_req_tag_i = 11'd0;
      rst_nb = 1;
      lows = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("s_i_accept", 32'(ifb.mem_i_accept_o), 32'((k % 4) != 3));
         chk("s_d_accept", 32'(ifb.mem_d_accept_o), 32'((k % 4) != 3));
         chk("s_i_valid", 32'(ifb.mem_i_valid_o), 32'(k > 0 && ((k - 1) % 4) != 3));
         chk("s_d_ack", 32'(ifb.mem_d_ack_o), 32'(k > 0 && ((k - 1) % 4) != 3));
         if (!ifb.mem_i_accept_o) lows++;
         if ((k % 4) != 3) q_b.push_back(mk(32'hA5A50001, 0, k));
         step(); ifb.mem_d_req_tag_i = TAG_W'(k + 1);
      end
      idle_b();
      chk("s_lows", 32'(lows), 32'd4);
      for (int k = 0; k < 10 && q_b.size() != 0; k++) step();
      chk("b_drain", 32'(q_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
